// File: rtl/kgp_wb_pkg.sv
// Shared types and widths for the writeback queue: register/data widths and the queued {reg, data} entry.
package kgp_wb_pkg;

    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int COUNT_W = 3;

    typedef struct packed {
        logic [REG_W-1:0]  regNum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t makeEntry(input logic [REG_W-1:0] regNum, input logic [DATA_W-1:0] data);
        wb_entry_t e;
        e.regNum = regNum;
        e.data   = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular storage for pending register writes; accepts up to two pushes (A older than B) and one pop per edge.
module wb_fifo
    import kgp_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             pushA,
    input  wb_entry_t        entryA,
    input  logic             pushB,
    input  wb_entry_t        entryB,
    input  logic             pop,
    output wb_entry_t        head,
    output wb_entry_t        slots [DEPTH],
    output logic [PTR_W-1:0] rdPtr,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    wb_entry_t        storage [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [OCC_W-1:0] pushNum;
    logic             popEff;

    // B is only meaningful alongside A, so it always lands in the slot after A
    assign pushNum = OCC_W'(pushA) + OCC_W'(pushA & pushB);
    assign popEff  = pop && (occupancy != '0);

    always_ff @(posedge Clk) begin
        if (pushA) begin
            storage[wrPtr] <= entryA;
        end
        if (pushA && pushB) begin
            storage[wrPtr + PTR_ONE] <= entryB;
        end
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
        end else begin
            wrPtr     <= wrPtr + pushNum[PTR_W-1:0];
            rdPtr     <= rdPtr + PTR_W'(popEff);
            occupancy <= occupancy + pushNum - OCC_W'(popEff);
        end
    end

    assign head  = storage[rdPtr];
    assign slots = storage;

endmodule

// File: rtl/wb_queue.sv
// Writeback queue merging load and ALU results onto one register-file write port.
// Forwarding from pending writes is built only when KGP_WB_FWD_EN is defined.
module wb_queue
    import kgp_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               Clk,
    input  logic               rst,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [REG_W-1:0]   mem_reg,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [REG_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]  alu_data,
    output logic [REG_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]  WriteData,
    output logic               RegWrite,
    input  logic [REG_W-1:0]   ReadReg1,
    input  logic [REG_W-1:0]   ReadReg2,
    output logic               fwd1_valid,
    output logic [DATA_W-1:0]  fwd1_data,
    output logic               fwd2_valid,
    output logic [DATA_W-1:0]  fwd2_data,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || DEPTH > (1 << COUNT_W) - 1) begin : gDepthCheck
        $error("wb_queue: DEPTH must be a power of two between 2 and 4");
    end

    logic             memAccept;
    logic             aluAccept;
    logic             pushA;
    logic             pushB;
    wb_entry_t        entryA;
    wb_entry_t        entryB;
    wb_entry_t        head;
    wb_entry_t        slots [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [OCC_W-1:0] occupancy;

    // Readiness looks only at registered occupancy so valid never feeds back into ready
    assign mem_ready = occupancy < OCC_W'(DEPTH);
    assign alu_ready = occupancy < OCC_W'(DEPTH - 1);

    assign memAccept = mem_valid && mem_ready;
    assign aluAccept = alu_valid && alu_ready;

    assign pushA  = memAccept || aluAccept;
    assign pushB  = memAccept && aluAccept;
    assign entryA = memAccept ? makeEntry(mem_reg, mem_data) : makeEntry(alu_reg, alu_data);
    assign entryB = makeEntry(alu_reg, alu_data);

    wb_fifo #(
        .DEPTH(DEPTH)
    ) uFifo (
        .Clk       (Clk),
        .rst       (rst),
        .pushA     (pushA),
        .entryA    (entryA),
        .pushB     (pushB),
        .entryB    (entryB),
        .pop       (occupancy != '0),
        .head      (head),
        .slots     (slots),
        .rdPtr     (rdPtr),
        .occupancy (occupancy)
    );

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (occupancy != '0) begin
            RegWrite  <= 1'b1;
            WriteReg  <= head.regNum;
            WriteData <= head.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    assign count = COUNT_W'(occupancy);

`ifdef KGP_WB_FWD_EN
    logic [REG_W-1:0]  readAddr [2];
    logic              fwdHit   [2];
    logic [DATA_W-1:0] fwdVal   [2];

    assign readAddr[0] = ReadReg1;
    assign readAddr[1] = ReadReg2;

    // Scan oldest to youngest so the last hit wins; the output register is older than every queue entry
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwdHit[p] = 1'b0;
            fwdVal[p] = '0;
            if (RegWrite && WriteReg == readAddr[p]) begin
                fwdHit[p] = 1'b1;
                fwdVal[p] = WriteData;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (OCC_W'(i) < occupancy && slots[rdPtr + PTR_W'(i)].regNum == readAddr[p]) begin
                    fwdHit[p] = 1'b1;
                    fwdVal[p] = slots[rdPtr + PTR_W'(i)].data;
                end
            end
        end
    end

    assign fwd1_valid = rst && fwdHit[0];
    assign fwd1_data  = rst ? fwdVal[0] : '0;
    assign fwd2_valid = rst && fwdHit[1];
    assign fwd2_data  = rst ? fwdVal[1] : '0;
`else
    logic [$bits(wb_entry_t)-1:0] unusedSlotBits;
    logic                         unusedFwd;

    always_comb begin
        unusedSlotBits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            unusedSlotBits = unusedSlotBits ^ slots[i];
        end
    end

    assign unusedFwd  = ^{ReadReg1, ReadReg2, rdPtr, unusedSlotBits};
    assign fwd1_valid = 1'b0;
    assign fwd1_data  = '0;
    assign fwd2_valid = 1'b0;
    assign fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model compared every cycle, plus directed literal checks.
module tb_wb_queue;

    localparam int DEPTH = 4;

    logic        Clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic        fwd1_valid;
    logic [31:0] fwd1_data;
    logic        fwd2_valid;
    logic [31:0] fwd2_data;
    logic [2:0]  count;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk        (Clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_reg    (mem_reg),
        .mem_data   (mem_data),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_reg    (alu_reg),
        .alu_data   (alu_data),
        .WriteReg   (WriteReg),
        .WriteData  (WriteData),
        .RegWrite   (RegWrite),
        .ReadReg1   (ReadReg1),
        .ReadReg2   (ReadReg2),
        .fwd1_valid (fwd1_valid),
        .fwd1_data  (fwd1_data),
        .fwd2_valid (fwd2_valid),
        .fwd2_data  (fwd2_data),
        .count      (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference model: a plain queue of pending writes plus the write-port register
    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        mdlQ[$];
    bit          mdlRW = 1'b0;
    logic [4:0]  mdlWR = '0;
    logic [31:0] mdlWD = '0;

    always @(posedge Clk or negedge rst) begin
        bit   takeMem;
        bit   takeAlu;
        int   sz;
        ent_t h;
        if (!rst) begin
            mdlQ.delete();
            mdlRW = 1'b0;
            mdlWR = '0;
            mdlWD = '0;
        end else begin
            sz      = mdlQ.size();
            takeMem = mem_valid && (DEPTH - sz >= 1);
            takeAlu = alu_valid && (DEPTH - sz >= 2);
            if (sz > 0) begin
                h     = mdlQ.pop_front();
                mdlRW = 1'b1;
                mdlWR = h.r;
                mdlWD = h.d;
            end else begin
                mdlRW = 1'b0;
            end
            if (takeMem) mdlQ.push_back('{r: mem_reg, d: mem_data});
            if (takeAlu) mdlQ.push_back('{r: alu_reg, d: alu_data});
        end
    end

    function automatic void fwdModel(input logic [4:0] r, output logic v, output logic [31:0] d);
        v = 1'b0;
        d = '0;
`ifdef KGP_WB_FWD_EN
        if (mdlRW && mdlWR == r) begin
            v = 1'b1;
            d = mdlWD;
        end
        foreach (mdlQ[i]) begin
            if (mdlQ[i].r == r) begin
                v = 1'b1;
                d = mdlQ[i].d;
            end
        end
`endif
    endfunction

    always @(negedge Clk) begin
        logic        v;
        logic [31:0] d;
        if (rst) begin
            chk("mdl_regwrite", RegWrite, mdlRW);
            chk("mdl_writereg", WriteReg, mdlWR);
            chk("mdl_writedata", WriteData, mdlWD);
            chk("mdl_count", count, mdlQ.size());
            chk("mdl_mem_ready", mem_ready, (DEPTH - mdlQ.size()) >= 1);
            chk("mdl_alu_ready", alu_ready, (DEPTH - mdlQ.size()) >= 2);
            fwdModel(ReadReg1, v, d);
            chk("mdl_fwd1_valid", fwd1_valid, v);
            chk("mdl_fwd1_data", fwd1_data, d);
            fwdModel(ReadReg2, v, d);
            chk("mdl_fwd2_valid", fwd2_valid, v);
            chk("mdl_fwd2_data", fwd2_data, d);
        end
    end

    initial begin
        #2;
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_writereg", WriteReg, 0);
        chk("rst_writedata", WriteData, 0);
        chk("rst_count", count, 0);
        chk("rst_mem_ready", mem_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        @(negedge Clk);
        rst = 1'b1;
        tick();

        // single ALU write, one cycle of queue latency
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'd5;
        tick();
        alu_valid = 1'b0;
        chk("single_lat_regwrite", RegWrite, 0);
        chk("single_lat_count", count, 1);
        tick();
        chk("single_regwrite", RegWrite, 1);
        chk("single_writereg", WriteReg, 1);
        chk("single_writedata", WriteData, 5);
        tick();
        chk("single_idle_regwrite", RegWrite, 0);
        chk("single_hold_writereg", WriteReg, 1);

        // dual issue: mem is older than alu
        mem_valid = 1'b1; mem_reg = 5'd0; mem_data = 32'd4;
        alu_valid = 1'b1; alu_reg = 5'd1; alu_data = 32'd5;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        chk("dual_first_regwrite", RegWrite, 1);
        chk("dual_first_reg", WriteReg, 0);
        chk("dual_first_data", WriteData, 4);
        tick();
        chk("dual_second_reg", WriteReg, 1);
        chk("dual_second_data", WriteData, 5);
        tick();
        chk("dual_idle_regwrite", RegWrite, 0);

        // saturation with both sources always valid
        for (int i = 0; i < 8; i++) begin
            mem_valid = 1'b1; mem_reg = 5'(16 + i); mem_data = 32'(100 + i);
            alu_valid = 1'b1; alu_reg = 5'(24 + i); alu_data = 32'(200 + i);
            tick();
            chk("full_bound", count <= 3'd4, 1);
            if (count >= 3'd3) chk("full_alu_ready", alu_ready, 0);
            if (count == 3'd4) chk("full_mem_ready", mem_ready, 0);
            if (i == 2) begin
                chk("full_count3", count, 3);
                chk("full_mem_ready_at3", mem_ready, 1);
            end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        repeat (5) tick();
        chk("drain_count", count, 0);
        chk("drain_regwrite", RegWrite, 0);

        // forwarding: youngest of two pending writes to r2 wins
        ReadReg1 = 5'd2; ReadReg2 = 5'd9;
        mem_valid = 1'b1; mem_reg = 5'd2; mem_data = 32'd7;
        alu_valid = 1'b1; alu_reg = 5'd2; alu_data = 32'd9;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
`ifdef KGP_WB_FWD_EN
        chk("fwd_queued_valid", fwd1_valid, 1);
        chk("fwd_queued_data", fwd1_data, 9);
        chk("fwd_other_valid", fwd2_valid, 0);
        tick();
        chk("fwd_mixed_data", fwd1_data, 9);
        tick();
        chk("fwd_outreg_valid", fwd1_valid, 1);
        chk("fwd_outreg_data", fwd1_data, 9);
        tick();
        chk("fwd_gone_valid", fwd1_valid, 0);
`else
        chk("nofwd_valid", fwd1_valid, 0);
        chk("nofwd_data", fwd1_data, 0);
        repeat (3) tick();
`endif
        ReadReg1 = '0; ReadReg2 = '0;

        // ten sequential writes wrap the pointers several times
        for (int i = 0; i <= 10; i++) begin
            mem_valid = 1'b0; alu_valid = 1'b0;
            if (i < 10) begin
                if (i % 2 == 1) begin
                    mem_valid = 1'b1; mem_reg = 5'(3 + i); mem_data = 32'(2 * (3 + i));
                end else begin
                    alu_valid = 1'b1; alu_reg = 5'(3 + i); alu_data = 32'(2 * (3 + i));
                end
            end
            tick();
            if (i >= 1) begin
                chk("wrap_regwrite", RegWrite, 1);
                chk("wrap_reg", WriteReg, 32'(2 + i));
                chk("wrap_data", WriteData, 32'(2 * (2 + i)));
            end
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        chk("wrap_idle_regwrite", RegWrite, 0);

        // reset mid-stream with three entries pending
        mem_valid = 1'b1; mem_reg = 5'd20; mem_data = 32'hA0;
        alu_valid = 1'b1; alu_reg = 5'd21; alu_data = 32'hA1;
        tick();
        mem_reg = 5'd22; mem_data = 32'hA2;
        alu_reg = 5'd23; alu_data = 32'hA3;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        ReadReg1 = 5'd22;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_regwrite", RegWrite, 0);
        chk("midrst_count", count, 0);
        chk("midrst_writereg", WriteReg, 0);
        chk("midrst_writedata", WriteData, 0);
        chk("midrst_fwd1_valid", fwd1_valid, 0);
        chk("midrst_fwd1_data", fwd1_data, 0);
        tick();
        chk("midrst_hold_regwrite", RegWrite, 0);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_stale_regwrite", RegWrite, 0);
            chk("no_stale_count", count, 0);
        end

        // normal acceptance resumes after reset
        alu_valid = 1'b1; alu_reg = 5'd20; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        tick();
        chk("resume_regwrite", RegWrite, 1);
        chk("resume_reg", WriteReg, 20);
        chk("resume_data", WriteData, 32'h1234);
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning writeback queue entries (power of two, min 2).
REQ-002 SHALL have port Clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports mem_valid input 1, mem_ready output 1, mem_reg input 5, mem_data input 32: load-result writeback request.
REQ-005 SHALL have ports alu_valid input 1, alu_ready output 1, alu_reg input 5, alu_data input 32: ALU-result writeback request.
REQ-006 SHALL have ports WriteReg output 5, WriteData output 32, RegWrite output 1, driving the register file write port directly.
REQ-007 SHALL have ports ReadReg1 input 5, ReadReg2 input 5: register-file read addresses, snooped for forwarding.
REQ-008 SHALL have ports fwd1_valid output 1, fwd1_data output 32, fwd2_valid output 1, fwd2_data output 32: forwarding results.
REQ-009 SHALL have port count output 3: current queue occupancy.

Function
REQ-010 SHALL hold pending writes in a circular FIFO of DEPTH {reg,data} entries; wr/rd pointers wrap modulo DEPTH.
REQ-011 SHALL derive mem_ready = (free >= 1) and alu_ready = (free >= 2) from registered occupancy only, never from any valid input.
REQ-012 SHALL accept a request on a rising edge when valid and ready are both high; both requests in one edge enqueue mem first (older), then alu.
REQ-013 SHALL pop the head on every edge where occupancy > 0, registering it onto WriteReg/WriteData with RegWrite=1 for the following cycle.
REQ-014 SHALL drive RegWrite=0 in any cycle following an edge with empty queue; WriteReg/WriteData hold last values.
REQ-015 SHALL give latency: request accepted at edge k into an empty queue -> RegWrite=1 during cycle k+1..k+2 -> register file written at edge k+2.
REQ-016 SHALL keep count unchanged on simultaneous single enqueue and pop, and update by +2-1 on double enqueue with pop.
REQ-017 SHALL treat register 0 like any other destination (no suppression).
REQ-018 SHALL compute fwdN_valid combinationally as 1 when ReadRegN matches any valid queue entry or (RegWrite and WriteReg); fwdN_data is the youngest match, queue entries younger than the registered output.
REQ-019 SHALL never overflow: occupancy is bounded by DEPTH through REQ-011; count equals DEPTH when full.

Reset
REQ-020 SHALL, on rst low, immediately clear pointers, count=0, RegWrite=0, WriteReg=0, WriteData=0, regardless of clock.
REQ-021 SHALL discard all queued entries on reset mid-operation; fwd outputs read 0 while reset is held.
REQ-022 SHALL resume normal acceptance on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL compile forwarding logic only when macro KGP_WB_FWD_EN is defined; when undefined fwd1_valid/fwd2_valid and fwd1_data/fwd2_data are tied to 0 and the ports remain.

Structure
REQ-024 SHALL take REG_W=5, DATA_W=32 and typedef wb_entry_t {reg, data} from shared package kgp_wb_pkg.
REQ-025 SHALL implement storage and pointer logic in sub-module wb_fifo; arbitration, output register and forwarding stay in wb_queue.

Verification
REQ-026 SHALL cover reset: rst=0 mid-stream with 3 entries queued -> RegWrite=0 and count=0 immediately, no later write of those entries.
REQ-027 SHALL cover single write: alu_reg=1, alu_data=5 accepted at edge k -> RegWrite=1, WriteReg=1, WriteData=5 during cycle k+1.
REQ-028 SHALL cover dual issue: mem(r0,4) and alu(r1,5) same edge -> r0=4 written before r1=5 on consecutive cycles.
REQ-029 SHALL cover full: hold both valids with no drain opportunity beyond pop rate -> count never exceeds 4, alu_ready=0 at count>=3, mem_ready=0 at count=4.
REQ-030 SHALL cover forwarding (KGP_WB_FWD_EN): queue r2=7 then r2=9, ReadReg1=2 -> fwd1_valid=1, fwd1_data=9; without macro fwd1_valid=0.
REQ-031 SHALL cover pointer wrap: 10 sequential single writes r3..r12 with data=reg*2 -> all appear in order on WriteReg/WriteData.
